// File: rtl/qns_pkg.sv
// Shared constants and code helpers for the QNS modulator / DWA element matcher path.
// Codes are odd integers in [-n_elem, +n_elem]; the helpers map them to unit-element counts.
package qns_pkg;

  localparam int QNS_OUT_W  = 3;
  localparam int QNS_N_ELEM = 2 ** (QNS_OUT_W - 1) - 1;

  function automatic logic code_legal(input int code, input int n_elem = QNS_N_ELEM);
    return ((code % 2) != 0) && (code >= -n_elem) && (code <= n_elem);
  endfunction

  // Number of elements to fire; an illegal code fires none.
  function automatic int code2k(input int code, input int n_elem = QNS_N_ELEM);
    return code_legal(code, n_elem) ? ((code + n_elem) >>> 1) : 0;
  endfunction

endpackage

// File: rtl/dwa_dem_if.sv
// Sample / element-enable bundle between the modulator side and dwa_dem.
// usage_cnt exists only when DWA_USAGE_CNT_EN is defined.
interface dwa_dem_if #(
  parameter int OUT_W  = 3,
  parameter int N_ELEM = 3,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 16
);
  logic                    en;
  logic signed [OUT_W-1:0] in;
  logic                    err_clr;
  logic [N_ELEM-1:0]       elem;
  logic [PTR_W-1:0]        ptr;
  logic                    err;
`ifdef DWA_USAGE_CNT_EN
  logic [N_ELEM*CNT_W-1:0] usage_cnt;

  modport master (output en, in, err_clr, input elem, ptr, err, usage_cnt);
  modport slave  (input en, in, err_clr, output elem, ptr, err, usage_cnt);
`else
  modport master (output en, in, err_clr, input elem, ptr, err);
  modport slave  (input en, in, err_clr, output elem, ptr, err);
`endif
endinterface

// File: rtl/dwa_dem_rotator.sv
// Combinational rotated thermometer: sets k consecutive bits starting at ptr, wrapping mod N_ELEM.
module dwa_dem_rotator #(
  parameter int N_ELEM = 3,
  parameter int PTR_W  = 2
) (
  input  logic [PTR_W:0]    k,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_ELEM-1:0] elem
);

  // Element i fires when its distance from ptr (walking upward, wrapping) is below k.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    elem = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      int off;
      off = i - int'(ptr);
      if (off < 0) off += N_ELEM;
      elem[i] = (off < int'(k));
    end
  end

endmodule

// File: rtl/dwa_dem.sv
// Data-weighted-averaging dynamic element matcher: rotates a thermometer code over N_ELEM unit elements.
// Optional per-element saturating usage counters are built when DWA_USAGE_CNT_EN is defined.
module dwa_dem
  import qns_pkg::*;
#(
  parameter int OUT_W  = QNS_OUT_W,
  parameter int N_ELEM = 2 ** (OUT_W - 1) - 1,
  parameter int PTR_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1,
  parameter int CNT_W  = 16
) (
  input logic      clk,
  input logic      rstn,
  dwa_dem_if.slave bus
);

  localparam int            KW  = PTR_W + 1;
  localparam logic [PTR_W:0] N_K = KW'(N_ELEM);

  int                 code_s;
  logic               legal;
  logic [PTR_W:0]     k;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [N_ELEM-1:0]  elem_q;
  logic [N_ELEM-1:0]  elem_nxt;
  logic               err_q;

  // k never exceeds N_ELEM, so a single conditional subtract keeps ptr in range.
  always_comb begin
    code_s  = int'(bus.in);
    legal   = code_legal(code_s, N_ELEM);
    k       = KW'(code2k(code_s, N_ELEM));
    sum     = {1'b0, ptr_q} + k;
    ptr_nxt = (sum >= N_K) ? PTR_W'(sum - N_K) : PTR_W'(sum);
  end

  dwa_dem_rotator #(.N_ELEM(N_ELEM), .PTR_W(PTR_W)) u_rot (
    .k    (k),
    .ptr  (ptr_q),
    .elem (elem_nxt)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      elem_q <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (bus.en) begin
        elem_q <= elem_nxt;
        ptr_q  <= ptr_nxt;
      end
      // A new illegal sample outranks a simultaneous clear.
      if (bus.en && !legal) err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.elem = elem_q;
  assign bus.ptr  = ptr_q;
  assign bus.err  = err_q;

`ifdef DWA_USAGE_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_ELEM];

  // NOTE: these counters are plain flops, not a RAM, so each entry is cleared on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ELEM; i++) cnt_q[i] <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < N_ELEM; i++)
        if (elem_nxt[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    bus.usage_cnt = '0;
    for (int i = 0; i < N_ELEM; i++) bus.usage_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_dwa_dem.sv
// Scoreboard bench for dwa_dem: a driver pushes model expectations, a monitor pops and compares.
// Counter checks run only when DWA_USAGE_CNT_EN is defined.
module tb_dwa_dem;
  import qns_pkg::*;

  localparam int N  = 3;
  localparam int PW = 2;

  typedef struct packed {
    logic [N-1:0]  elem;
    logic [PW-1:0] ptr;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dwa_dem_if #(.OUT_W(3), .N_ELEM(N), .PTR_W(PW), .CNT_W(16)) bus ();
  dwa_dem #(.OUT_W(3), .N_ELEM(N), .PTR_W(PW), .CNT_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

`ifdef DWA_USAGE_CNT_EN
  dwa_dem_if #(.OUT_W(3), .N_ELEM(N), .PTR_W(PW), .CNT_W(4)) bus2 ();
  dwa_dem #(.OUT_W(3), .N_ELEM(N), .PTR_W(PW), .CNT_W(4)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  // Reference model state: pointer as an integer, elements as a bit vector, counts per element.
  int           m_ptr;
  logic [N-1:0] m_elem;
  logic         m_err;
  int           m_cnt [N];
  int           m_sum_k;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_elem = '0; m_err = 1'b0; m_sum_k = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input bit e, input int code, input bit clr);
    bit ok;
    int kk;
    ok = (code % 2 != 0) && (code >= -N) && (code <= N);
    if (e) begin
      kk = ok ? (code + N) / 2 : 0;
      m_elem = '0;
      for (int j = 0; j < kk; j++) begin
        m_elem[(m_ptr + j) % N] = 1'b1;
        m_cnt[(m_ptr + j) % N]++;
      end
      m_ptr = (m_ptr + kk) % N;
      m_sum_k += kk;
    end
    if (e && !ok) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic drive(input bit e, input int code, input bit clr);
    exp_t x;
    @(negedge clk);
    bus.en      = e;
    bus.in      = 3'(code);
    bus.err_clr = clr;
    model_step(e, code, clr);
    x.elem = m_elem;
    x.ptr  = PW'(m_ptr);
    x.err  = m_err;
    q.push_back(x);
  endtask

  // Monitor: the DUT presents a new output state one cycle after each driven sample.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && q.size() > 0) begin
        x = q.pop_front();
        check("elem", bus.elem, x.elem);
        check("ptr", bus.ptr, x.ptr);
        check("err", bus.err, x.err);
      end
    end
  end

  task automatic drain();
    int budget;
    drive(1'b0, 0, 1'b0);
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #3;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int codes_legal [4] = '{-3, -1, 1, 3};
  int codes_bad   [4] = '{-4, -2, 0, 2};

  initial begin
    bus.en = 1'b0; bus.in = '0; bus.err_clr = 1'b0;
`ifdef DWA_USAGE_CNT_EN
    bus2.en = 1'b0; bus2.in = '0; bus2.err_clr = 1'b0;
`endif
    model_reset();
    #12;
    check("rst_elem", bus.elem, 0);
    check("rst_ptr", bus.ptr, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic rotation, full / empty codes and pointer wrap.
    drive(1, 1, 0); drive(1, 1, 0);
    drive(1, 3, 0); drive(1, -3, 0);
    drive(1, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, -1, 0);

    // Hold with en low while in toggles, then illegal codes and clear priority.
    for (int i = 0; i < 5; i++) drive(0, codes_legal[$urandom_range(3)], 0);
    drive(1, -4, 0);
    drive(1, 2, 1);
    drive(0, 0, 1);

    // Build ptr=2, elem=111, err=1, then reset asynchronously between edges.
    drive(1, -2, 0); drive(1, -1, 0); drive(1, 3, 0);
    drain();
    check("pre_rst_elem", bus.elem, 3'b111);
    check("pre_rst_err", bus.err, 1);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check("async_elem", bus.elem, 0);
    check("async_ptr", bus.ptr, 0);
    check("async_err", bus.err, 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 1, 0);
    drain();

    // Randomised mix of legal/illegal codes, en gaps and clears.
    for (int i = 0; i < 400; i++) begin
      bit e, clr;
      int c;
      e   = ($urandom_range(9) < 8);
      clr = ($urandom_range(9) == 0);
      c   = ($urandom_range(3) == 0) ? codes_bad[$urandom_range(3)] : codes_legal[$urandom_range(3)];
      drive(e, c, clr);
    end
    drain();

`ifdef DWA_USAGE_CNT_EN
    do_reset();
    for (int i = 0; i < N; i++) check("cnt_rst", bus.usage_cnt[i*16 +: 16], 0);
    for (int i = 0; i < 3000; i++) drive(1, codes_legal[$urandom_range(3)], 0);
    drain();
    begin
      longint tot;
      tot = 0;
      for (int i = 0; i < N; i++) begin
        // Starting from element 0, element i has fired once per j < S with j mod N == i.
        check("cnt_rr", bus.usage_cnt[i*16 +: 16], (m_sum_k + N - 1 - i) / N);
        check("cnt_model", bus.usage_cnt[i*16 +: 16], m_cnt[i]);
        tot += bus.usage_cnt[i*16 +: 16];
      end
      check("cnt_sum", tot, m_sum_k);
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus2.en = 1'b1;
      bus2.in = 3'sd3;
    end
    @(negedge clk);
    bus2.en = 1'b0;
    for (int i = 0; i < N; i++) check("cnt_sat", bus2.usage_cnt[i*4 +: 4], 15);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
